// File: rtl/ewrap_ctrl.sv
// EWRAP loopback sequencer: switches the SIPO source on code-group boundaries,
// blanks received data while the new source settles, and strobes symbol loads.
module ewrap_ctrl #(
  parameter int DATA_WIDTH     = 10,
  parameter int CNT_W          = 4,
  parameter int SETTLE_SYMBOLS = 2
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             pma_enable,
  input  logic             EWRAP_req,
  output logic             EWRAP,
  output logic             sipo_load,
  output logic             rx_data_valid,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [1:0]       state,
  output logic             mode_switch_done
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    STABLE = 2'b01,
    SYNC   = 2'b10,
    SETTLE = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(DATA_WIDTH - 1);
  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_SYMBOLS - 1);

  state_t           state_q, state_d;
  logic             ewrap_q, ewrap_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [3:0]       settle_cnt_q, settle_cnt_d;
  logic             done_q, done_d;
  logic             load;
  logic             req_diff;

  assign load             = pma_enable & (bit_cnt_q == LAST_BIT);
  assign req_diff         = (EWRAP_req != ewrap_q);
  assign EWRAP            = ewrap_q;
  assign sipo_load        = load;
  assign rx_data_valid    = load & (state_q == STABLE);
  assign bit_cnt          = bit_cnt_q;
  assign state            = state_q;
  assign mode_switch_done = done_q;

  always_comb begin
    bit_cnt_d    = '0;
    state_d      = state_q;
    ewrap_d      = ewrap_q;
    settle_cnt_d = settle_cnt_q;
    done_d       = 1'b0;

    if (pma_enable && !load) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    // Losing the enable overrides every other event outside IDLE.
    if (state_q != IDLE && !pma_enable) begin
      state_d      = IDLE;
      settle_cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ewrap_d = EWRAP_req;
          if (pma_enable) begin
            state_d      = SETTLE;
            settle_cnt_d = '0;
          end
        end
        STABLE: begin
          if (req_diff) state_d = SYNC;
        end
        SYNC: begin
          if (!req_diff) begin
            state_d = STABLE;
          end else if (load) begin
            ewrap_d      = EWRAP_req;
            state_d      = SETTLE;
            settle_cnt_d = '0;
          end
        end
        SETTLE: begin
          // A new request wins over settle completion in the same cycle.
          if (req_diff) begin
            state_d = SYNC;
          end else if (load) begin
            if (settle_cnt_q != 4'hF) settle_cnt_d = settle_cnt_q + 4'd1;
            if (settle_cnt_q == SETTLE_LAST) begin
              state_d = STABLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      ewrap_q      <= 1'b0;
      bit_cnt_q    <= '0;
      settle_cnt_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      ewrap_q      <= ewrap_d;
      bit_cnt_q    <= bit_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_ewrap_ctrl.sv
// Self-checking bench for ewrap_ctrl: directed scenarios then random traffic,
// every cycle compared against a symbol-level reference model.
module tb_ewrap_ctrl;

  localparam int DW = 10;
  localparam int CW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          pma_enable;
  logic          EWRAP_req;
  logic          EWRAP;
  logic          sipo_load;
  logic          rx_data_valid;
  logic [CW-1:0] bit_cnt;
  logic [1:0]    state;
  logic          mode_switch_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: running flag, position in code group, current source,
  // pending switch, symbols still to blank, completion pulse.
  bit m_run, m_sel, m_sync, m_done;
  int m_pos, m_blank;

  // Last observed values, captured during each step's check.
  logic obs_valid, obs_done, obs_load, obs_ewrap;

  ewrap_ctrl #(.DATA_WIDTH(DW), .CNT_W(CW), .SETTLE_SYMBOLS(SS)) dut (
    .clk              (clk),
    .reset_L          (reset_L),
    .pma_enable       (pma_enable),
    .EWRAP_req        (EWRAP_req),
    .EWRAP            (EWRAP),
    .sipo_load        (sipo_load),
    .rx_data_valid    (rx_data_valid),
    .bit_cnt          (bit_cnt),
    .state            (state),
    .mode_switch_done (mode_switch_done)
  );

  always #5 clk = ~clk;

  function automatic int modelState();
    if (!m_run) return 0;
    if (m_sync) return 2;
    if (m_blank > 0) return 3;
    return 1;
  endfunction

  task automatic modelReset();
    m_run = 0; m_sel = 0; m_sync = 0; m_done = 0; m_pos = 0; m_blank = 0;
  endtask

  // Advance the model by one clock using the inputs sampled at the edge.
  task automatic modelEdge();
    bit en, req, ld;
    en = pma_enable;
    req = EWRAP_req;
    ld = en && (m_pos == DW - 1);
    m_done = 0;
    if (!m_run) begin
      m_sel = req;
      if (en) begin
        m_run = 1; m_blank = SS; m_sync = 0;
      end
    end else if (!en) begin
      m_run = 0; m_sync = 0; m_blank = 0;
    end else if (m_sync) begin
      if (req == m_sel) begin
        m_sync = 0;
      end else if (ld) begin
        m_sel = req; m_sync = 0; m_blank = SS;
      end
    end else if (req != m_sel) begin
      m_sync = 1; m_blank = 0;
    end else if (m_blank > 0 && ld) begin
      m_blank--;
      if (m_blank == 0) m_done = 1;
    end
    m_pos = en ? ((m_pos == DW - 1) ? 0 : m_pos + 1) : 0;
  endtask

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    bit ld;
    ld = pma_enable && (m_pos == DW - 1);
    check1({tag, ".EWRAP"}, 32'(EWRAP), 32'(m_sel));
    check1({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(m_pos));
    check1({tag, ".state"}, 32'(state), 32'(modelState()));
    check1({tag, ".sipo_load"}, 32'(sipo_load), 32'(ld));
    check1({tag, ".rx_data_valid"}, 32'(rx_data_valid), 32'(ld && modelState() == 1));
    check1({tag, ".mode_switch_done"}, 32'(mode_switch_done), 32'(m_done));
    obs_valid = rx_data_valid;
    obs_done  = mode_switch_done;
    obs_load  = sipo_load;
    obs_ewrap = EWRAP;
  endtask

  // Called just after a rising edge: drive, check at the falling edge, clock model.
  task automatic applyStimulus(input bit en, input bit req, input string tag);
    pma_enable = en;
    EWRAP_req  = req;
    @(negedge clk);
    checkOutput(tag);
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic enableRun(input string tag);
    int nValid, nDone, nLoad, doneCycle;
    nValid = 0; nDone = 0; nLoad = 0; doneCycle = -1;
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b1, 1'b0, tag);
      if (obs_valid) nValid++;
      if (obs_load) nLoad++;
      if (obs_done) begin
        nDone++;
        doneCycle = c;
      end
    end
    check1({tag, ".loads"}, 32'(nLoad), 32'd4);
    check1({tag, ".valids"}, 32'(nValid), 32'd2);
    check1({tag, ".pulses"}, 32'(nDone), 32'd1);
    check1({tag, ".pulse_cycle"}, 32'(doneCycle), 32'd20);
  endtask

  initial begin
    int k, nDone, guard;
    modelReset();
    reset_L = 1'b0;
    pma_enable = 1'b0;
    EWRAP_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_L = 1'b1;
    checkOutput("reset");
    check1("reset.state_const", 32'(state), 32'd0);

    // First enable with request low: two blanked symbols then steady valids.
    enableRun("enable");

    // Request loopback at bit 3; switch must land on the next boundary.
    guard = 0;
    while (m_pos != 3 && guard < 20) begin
      applyStimulus(1'b1, 1'b0, "align3");
      guard++;
    end
    k = 0;
    obs_ewrap = 1'b0;
    while (!obs_ewrap && k < 30) begin
      applyStimulus(1'b1, 1'b1, "switch");
      if (!obs_ewrap) k++;
    end
    check1("switch.latency", 32'(k), 32'd7);
    nDone = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(1'b1, 1'b1, "switch_settle");
      if (obs_done) nDone++;
    end
    check1("switch.pulses", 32'(nDone), 32'd1);

    // Short glitch on the request while in SYNC: no toggle, no pulse.
    guard = 0;
    while (m_pos != 1 && guard < 20) begin
      applyStimulus(1'b1, 1'b1, "align1");
      guard++;
    end
    nDone = 0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(1'b1, (c < 3) ? 1'b0 : 1'b1, "glitch");
      if (obs_done) nDone++;
    end
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b1, 1'b1, "glitch_after");
      if (obs_done) nDone++;
    end
    check1("glitch.pulses", 32'(nDone), 32'd0);
    check1("glitch.ewrap", 32'(EWRAP), 32'd1);

    // Switch to PMD, then revert after one blanked load.
    guard = 0;
    while (!(m_blank == SS - 1 && !m_sync && m_run) && guard < 40) begin
      applyStimulus(1'b1, 1'b0, "to_pmd");
      guard++;
    end
    check1("revert.reached", 32'(guard < 40), 32'd1);
    nDone = 0;
    for (int c = 0; c < 45; c++) begin
      applyStimulus(1'b1, 1'b1, "revert");
      if (obs_done) nDone++;
    end
    check1("revert.pulses", 32'(nDone), 32'd1);

    // Drop enable at bit 6 while in loopback.
    guard = 0;
    while (m_pos != 6 && guard < 20) begin
      applyStimulus(1'b1, 1'b1, "align6");
      guard++;
    end
    applyStimulus(1'b0, 1'b1, "disable");
    @(negedge clk);
    check1("disable.state", 32'(state), 32'd0);
    check1("disable.bit_cnt", 32'(bit_cnt), 32'd0);
    check1("disable.ewrap", 32'(EWRAP), 32'd1);
    @(posedge clk);
    #1;
    m_sel = 1'b1;
    nDone = 0;
    for (int c = 0; c < 25; c++) begin
      applyStimulus(1'b1, 1'b1, "reenable");
      if (obs_done) nDone++;
    end
    check1("reenable.pulses", 32'(nDone), 32'd1);

    // Asynchronous reset in the middle of SETTLE.
    guard = 0;
    while (m_run && guard < 5) begin
      applyStimulus(1'b0, 1'b0, "predisable");
      guard++;
    end
    for (int c = 0; c < 12; c++) applyStimulus(1'b1, 1'b1, "settle_pre_reset");
    #2;
    reset_L = 1'b0;
    #1;
    modelReset();
    check1("async.state", 32'(state), 32'd0);
    check1("async.ewrap", 32'(EWRAP), 32'd0);
    check1("async.bit_cnt", 32'(bit_cnt), 32'd0);
    pma_enable = 1'b0;
    EWRAP_req = 1'b0;
    @(posedge clk);
    #3;
    reset_L = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, "post_reset");
    enableRun("reenable_after_reset");

    // Random traffic against the model.
    for (int c = 0; c < 2000; c++) begin
      bit en, req;
      en  = ($urandom_range(0, 40) != 0);
      req = ($urandom_range(0, 11) == 0) ? ~EWRAP_req : EWRAP_req;
      applyStimulus(en, req, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ewrap_ctrl.md
Name: ewrap_ctrl

Overview:
Sequencer for the PMA receive-side loopback path. Owns the EWRAP select that steers either PMD_UNITDATA_indication or the PISO serial output into the SIPO. Changes the select only on code-group boundaries and blanks the received data until the new source has settled. Also supplies the SIPO symbol-load strobe and a qualified receive-valid signal.

Parameters:
DATA_WIDTH, 10, bits per code group (SIPO width)
CNT_W, 4, width of the bit counter; must satisfy 2^CNT_W >= DATA_WIDTH
SETTLE_SYMBOLS, 2, symbols blanked after a select change or enable; legal range 1..15

Ports:
clk  input  1  bit clock, rising-edge
reset_L  input  1  asynchronous active-low reset
pma_enable  input  1  receive path enable, synchronous to clk
EWRAP_req  input  1  requested loopback mode from management, synchronous to clk
EWRAP  output  1  registered select to the SIPO input mux; 1 = PISO loopback, 0 = PMD
sipo_load  output  1  one-cycle strobe; SIPO holds a complete code group
rx_data_valid  output  1  sipo_load qualified by the STABLE state
bit_cnt  output  CNT_W  bit position within the current code group
state  output  2  FSM state: IDLE=00, STABLE=01, SYNC=10, SETTLE=11
mode_switch_done  output  1  one-cycle pulse on the SETTLE->STABLE transition

Behaviour:
- Reset (reset_L=0, asynchronous): state=IDLE, EWRAP=0, bit_cnt=0, settle_cnt=0, mode_switch_done=0. sipo_load and rx_data_valid are therefore 0.
- Bit counter:
  - While pma_enable=1: counts 0..DATA_WIDTH-1 each clk and wraps to 0.
  - While pma_enable=0: held at 0.
- sipo_load = pma_enable & (bit_cnt==DATA_WIDTH-1). This is a combinational decode of registered values.
- rx_data_valid = sipo_load & (state==STABLE).
- IDLE:
  - EWRAP tracks EWRAP_req with one cycle of register latency.
  - On pma_enable=1: go to SETTLE with settle_cnt=0.
- STABLE:
  - If EWRAP_req != EWRAP, go to SYNC.
  - EWRAP is held.
- SYNC:
  - Waits for the sipo_load cycle.
  - On that edge, EWRAP <= EWRAP_req and the FSM goes to SETTLE with settle_cnt=0. Bit 0 of the next code group therefore comes from the new source.
  - If EWRAP_req returns to equal EWRAP before the boundary, go back to STABLE with no toggle and no pulse.
  - Worst-case latency from a request change to the EWRAP change is DATA_WIDTH+1 clks.
- SETTLE:
  - settle_cnt increments on each sipo_load.
  - When a sipo_load occurs with settle_cnt==SETTLE_SYMBOLS-1: go to STABLE and pulse mode_switch_done for 1 clk on the following cycle.
  - If EWRAP_req != EWRAP at any point, go to SYNC. The settle is abandoned and restarts after the switch.
- Any state except IDLE: pma_enable=0 forces IDLE on the next edge and clears bit_cnt and settle_cnt. EWRAP then follows EWRAP_req.
- Simultaneous events:
  - pma_enable deassertion has priority over everything.
  - A request mismatch has priority over settle completion in the same cycle: go to SYNC, no pulse.
- Reset mid-operation: immediate return to the reset values. No boundary alignment is attempted.
- The settle counter is 4 bits and saturates; it never wraps.

Test Plan:
- Reset, then pma_enable=1 with EWRAP_req=0 held -> rx_data_valid=0 for the first 2 sipo_loads (cycles 9 and 19 after enable). Then rx_data_valid=1 every 10 clks, and mode_switch_done pulses once at cycle 20.
- In STABLE with bit_cnt=3, EWRAP_req 0->1 -> state=SYNC, EWRAP stays 0 until bit_cnt=9. EWRAP=1 when bit_cnt=0. The next 2 loads are blanked, then valid resumes and mode_switch_done pulses.
- In SYNC, EWRAP_req 0->1->0 within 4 clks, before the boundary -> return to STABLE. EWRAP never toggles, no blank symbols, no pulse.
- In SETTLE after 1 blanked load, EWRAP_req toggles back -> SYNC, EWRAP reverts at the next boundary, full 2-symbol settle follows, exactly one mode_switch_done pulse.
- pma_enable dropped mid-symbol (bit_cnt=6) in STABLE with EWRAP_req=1 -> next clk state=IDLE, bit_cnt=0, EWRAP=1. Re-enable -> SETTLE, 2 blanked loads.
- reset_L pulsed low mid-SETTLE, away from any clk edge -> outputs go to 0 immediately, asynchronously. After release, behaviour is identical to the first scenario.
